// File: rtl/overdrive_pkg.sv
// Shared types and helpers for the multi-channel overdrive effect.
package overdrive_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      CLIP,
      FINISH
   } state_t;

   localparam logic MODE_HARD = 1'b0;
   localparam logic MODE_SOFT = 1'b1;

   // Product width: the sample plus the largest possible left shift, so the gain never overflows.
   function automatic int unsigned calc_pw(input int unsigned width, input int unsigned gain_w);
      return width + (32'd1 << gain_w);
   endfunction

endpackage

// File: rtl/overdrive_clip_stage.sv
// Combinational symmetric hard/soft clipper: PW-bit signed product in, WIDTH-bit sample out.
module overdrive_clip_stage
   import overdrive_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned GAIN_W     = 3,
   parameter int unsigned CLIP_LEVEL = (32'd1 << (WIDTH - 2)) - 1,
   parameter int unsigned KNEE       = CLIP_LEVEL / 2
) (
   input  logic [calc_pw(WIDTH, GAIN_W)-1:0] prod,
   input  logic                              mode,
   output logic [WIDTH-1:0]                  clipped_c
);

   localparam int unsigned PW = calc_pw(WIDTH, GAIN_W);
   localparam logic [PW-1:0] CLIP_P = PW'(CLIP_LEVEL);
   localparam logic [PW-1:0] KNEE_P = PW'(KNEE);

   logic           neg;
   logic [PW-1:0]  mag;
   logic [PW-1:0]  soft_mag;
   logic [PW-1:0]  y_mag;
   logic [WIDTH-1:0] y_w;

   // Magnitude, knee compression, ceiling, then re-apply the sign (ceiling keeps the result symmetric).
   always_comb begin
      neg      = prod[PW-1];
      mag      = neg ? (PW'(0) - prod) : prod;
      soft_mag = KNEE_P + ((mag - KNEE_P) >> 2);
      y_mag    = mag;
      if ((mode == MODE_SOFT) && (mag > KNEE_P)) begin
         y_mag = soft_mag;
      end
      if (y_mag > CLIP_P) begin
         y_mag = CLIP_P;
      end
      y_w       = WIDTH'(y_mag);
      clipped_c = neg ? (WIDTH'(0) - y_w) : y_w;
   end

endmodule

// File: rtl/overdrive_effect_mc.sv
// Multi-channel overdrive: latches a frame on START, runs each channel through one shared
// gain/clip datapath, and raises DONE once the whole output frame is written.
module overdrive_effect_mc
   import overdrive_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned GAIN_W     = 3,
   parameter int unsigned CLIP_LEVEL = (32'd1 << (WIDTH - 2)) - 1,
   parameter int unsigned KNEE       = CLIP_LEVEL / 2
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      START,
   output logic                      DONE,
   input  logic [GAIN_W-1:0]         gain,
   input  logic                      mode,
   input  logic [CHANNELS*WIDTH-1:0] input_frame,
   output logic [CHANNELS*WIDTH-1:0] output_frame
);

   localparam int unsigned PW   = calc_pw(WIDTH, GAIN_W);
   localparam int unsigned FW   = CHANNELS * WIDTH;
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [GAIN_W-1:0] gain_q, gain_d;
   logic              mode_q, mode_d;
   logic [FW-1:0]     frame_q, frame_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [FW-1:0]     out_d;
   logic              done_d;
   logic [WIDTH-1:0]  sample;
   logic [WIDTH-1:0]  clipped_c;

   overdrive_clip_stage #(
      .WIDTH      (WIDTH),
      .GAIN_W     (GAIN_W),
      .CLIP_LEVEL (CLIP_LEVEL),
      .KNEE       (KNEE)
   ) u_clip (
      .prod      (prod_q),
      .mode      (mode_q),
      .clipped_c (clipped_c)
   );

   // State, latches, product and output registers; reset discards any frame in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         gain_q       <= '0;
         mode_q       <= MODE_HARD;
         frame_q      <= '0;
         prod_q       <= '0;
         output_frame <= '0;
         DONE         <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         gain_q       <= gain_d;
         mode_q       <= mode_d;
         frame_q      <= frame_d;
         prod_q       <= prod_d;
         output_frame <= out_d;
         DONE         <= done_d;
      end
   end

   // Next-state and datapath control: accept, multiply, clip per channel, then handshake.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      gain_d  = gain_q;
      mode_d  = mode_q;
      frame_d = frame_q;
      prod_d  = prod_q;
      out_d   = output_frame;
      done_d  = DONE;

      sample = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (ch_q == CH_W'(c)) sample = frame_q[c*WIDTH +: WIDTH];
      end

      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (START) begin
               frame_d = input_frame;
               gain_d  = gain;
               mode_d  = mode;
               ch_d    = '0;
               state_d = MULT;
            end
         end
         MULT: begin
            prod_d  = {{(PW-WIDTH){sample[WIDTH-1]}}, sample} << gain_q;
            state_d = CLIP;
         end
         CLIP: begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
               if (ch_q == CH_W'(c)) out_d[c*WIDTH +: WIDTH] = clipped_c;
            end
            if (ch_q == CH_W'(CHANNELS - 1)) begin
               done_d  = 1'b1;
               state_d = FINISH;
            end else begin
               ch_d    = ch_q + CH_W'(1);
               state_d = MULT;
            end
         end
         FINISH: begin
            if (!START) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_overdrive_effect_mc.sv
// Directed bench for overdrive_effect_mc with an edge-level behavioural model and per-cycle compare.
module tb_overdrive_effect_mc;

   localparam int W    = 16;
   localparam int CH   = 2;
   localparam int CLIP = 16383;
   localparam int KNEE = 8191;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          done;
   logic [2:0]    gain = '0;
   logic          mode = 1'b0;
   logic [31:0]   in_frame = '0;
   logic [31:0]   out_frame;

   int tests = 0;
   int fails = 0;

   overdrive_effect_mc dut (
      .CLK          (clk),
      .RESET        (rst),
      .START        (start),
      .DONE         (done),
      .gain         (gain),
      .mode         (mode),
      .input_frame  (in_frame),
      .output_frame (out_frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: gain as multiplication, clipping by magnitude rules.
   function automatic logic [15:0] model_sample(input logic [15:0] x, input int g, input bit m);
      longint p, mag, ym;
      p   = longint'($signed(x)) * (longint'(1) << g);
      mag = (p < 0) ? -p : p;
      if (m && mag > KNEE) ym = KNEE + (mag - KNEE) / 4;
      else                 ym = mag;
      if (ym > CLIP) ym = CLIP;
      if (p < 0) ym = -ym;
      return 16'(ym);
   endfunction

   function automatic logic [31:0] model_frame(input logic [31:0] f, input int g, input bit m);
      logic [15:0] lo, hi;
      lo = f[15:0];
      hi = f[31:16];
      return {model_sample(hi, g, m), model_sample(lo, g, m)};
   endfunction

   // Edge-level model: a frame is busy for 2*CH edges; channel k lands on edge 2k+2.
   bit          m_busy = 1'b0;
   bit          exp_done = 1'b0;
   int          m_cnt = 0;
   logic [31:0] exp_out = '0;
   logic [31:0] m_frame = '0;
   int          m_gain = 0;
   bit          m_mode = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0; exp_done = 1'b0; m_cnt = 0; exp_out = '0;
      end else if (!m_busy && !exp_done) begin
         if (start) begin
            m_busy = 1'b1; m_cnt = 0;
            m_frame = in_frame; m_gain = int'(gain); m_mode = mode;
         end
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt % 2 == 0) begin
            logic [15:0] s;
            int k;
            k = m_cnt / 2 - 1;
            s = m_frame[k*16 +: 16];
            exp_out[k*16 +: 16] = model_sample(s, m_gain, m_mode);
         end
         if (m_cnt == 2 * CH) begin
            m_busy = 1'b0; exp_done = 1'b1;
         end
      end else if (exp_done && !start) begin
         exp_done = 1'b0;
      end
   end

   // Per-cycle compare of DUT outputs against the model.
   always @(negedge clk) begin
      check("done_cycle", {31'b0, done}, {31'b0, exp_done});
      check("frame_cycle", out_frame, exp_out);
   end

   task automatic do_frame(input string name, input logic [31:0] f, input logic [2:0] g,
                           input bit m, input int hold, input bit chg, input bit rel,
                           input logic [31:0] exp_lit);
      int n;
      logic [31:0] res;
      check({name, "_model"}, model_frame(f, int'(g), m), exp_lit);
      @(negedge clk);
      in_frame = f; gain = g; mode = m; start = 1'b1;
      if (rel) rst = 1'b0;
      @(posedge clk);
      #2;
      if (chg) begin
         in_frame = ~f; gain = ~g; mode = ~m;
      end
      if (hold == 0) start = 1'b0;
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      check({name, "_latency"}, 32'(n), 32'd4);
      res = out_frame;
      check({name, "_result"}, res, exp_lit);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({name, "_held_done"}, {31'b0, done}, 32'd1);
         check({name, "_held_frame"}, out_frame, exp_lit);
         @(negedge clk);
         start = 1'b0;
      end
      @(posedge clk);
      #1;
      check({name, "_done_drop"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_frame", out_frame, 32'd0);
      @(negedge clk);
      @(negedge clk);
      do_frame("unity", 32'h3333_3333, 3'd0, 1'b0, 0, 1'b0, 1'b1, 32'h3333_3333);
      do_frame("hard_g1", 32'hCCCD_3333, 3'd1, 1'b0, 0, 1'b0, 1'b0, 32'hC001_3FFF);
      do_frame("soft_g0", 32'hCCCD_3333, 3'd0, 1'b1, 0, 1'b0, 1'b0, 32'hDB34_24CC);
      do_frame("soft_knee", 32'hCCCD_1000, 3'd0, 1'b1, 0, 1'b0, 1'b0, 32'hDB34_1000);
      do_frame("sat_g7", 32'h7FFF_8000, 3'd7, 1'b1, 0, 1'b0, 1'b0, 32'h3FFF_C001);
      do_frame("hold", 32'h3333_3333, 3'd0, 1'b0, 10, 1'b0, 1'b0, 32'h3333_3333);
      do_frame("fresh", 32'h0001_FFFF, 3'd2, 1'b0, 0, 1'b0, 1'b0, 32'h0004_FFFC);
      do_frame("latched", 32'h1000_2000, 3'd0, 1'b0, 0, 1'b1, 1'b0, 32'h1000_2000);

      // Asynchronous reset during the ch0 clip cycle of a frame in flight.
      @(negedge clk);
      in_frame = 32'h1234_5678; gain = 3'd1; mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_done", {31'b0, done}, 32'd0);
      check("async_rst_frame", out_frame, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_frame("after_rst", 32'h8000_8000, 3'd0, 1'b0, 0, 1'b0, 1'b0, 32'hC001_C001);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
